// File: rtl/vendor_pkg.sv
//------------------------------------------------------------------------------
// vendor_pkg : shared widths and write-path state encoding for the vendor slave
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vendor_pkg;

  localparam int VENDOR_SW_W = 18;
  localparam int AVL_DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin winner search, first request after last_grant
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Scan starts one past the previous winner so it drops to lowest priority.
  always_comb begin
    winner_o = last_grant_i;
    any_o    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!any_o && req_i[rot_idx(last_grant_i, off)]) begin
        any_o    = 1'b1;
        winner_o = rot_idx(last_grant_i, off);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vendor_wr_arbiter.sv
//------------------------------------------------------------------------------
// vendor_wr_arbiter : round-robin sharing of the vendor SW Avalon write port,
// with a forced idle gap after every write. Optional VENDOR_WR_ARB_LASTWR_EN
// adds last-write readback and a write counter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vendor_wr_arbiter
  import vendor_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = VENDOR_SW_W,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      chipselect,
  output logic                      write,
  output logic [AVL_DATA_W-1:0]     writedata,
  output logic                      busy
`ifdef VENDOR_WR_ARB_LASTWR_EN
  ,
  output logic [DATA_W-1:0]         last_wr_data,
  output logic [2:0]                last_wr_src,
  output logic [15:0]               wr_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = 8;

  wr_state_e            state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 wr_q;
  logic                 busy_q;
  logic [AVL_DATA_W-1:0] writedata_q;

  logic [IDX_W-1:0]     pick_winner;
  logic                 pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (pick_winner),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    ack_d        = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_winner;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_winner == IDX_W'(i)) data_d = req_data[i*DATA_W +: DATA_W];
          end
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_WRITE;
      ST_WRITE: begin
        last_grant_d = grant_q;
        if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so the strobe pattern is decoded from the next state.
    if (state_d == ST_WRITE) ack_d[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      grant_q      <= IDX_W'(NUM_REQ - 1);
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      data_q       <= '0;
      ack_q        <= '0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      writedata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      wr_q         <= (state_d == ST_WRITE);
      busy_q       <= (state_d != ST_IDLE);
      if (state_q == ST_GRANT) writedata_q <= AVL_DATA_W'(data_q);
    end
  end

  assign ack        = ack_q;
  assign chipselect = wr_q;
  assign write      = wr_q;
  assign writedata  = writedata_q;
  assign busy       = busy_q;

`ifdef VENDOR_WR_ARB_LASTWR_EN
  logic [DATA_W-1:0] last_wr_data_q;
  logic [2:0]        last_wr_src_q;
  logic [15:0]       wr_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr_data_q <= '0;
      last_wr_src_q  <= '0;
      wr_count_q     <= '0;
    end else if (state_q == ST_WRITE) begin
      last_wr_data_q <= data_q;
      last_wr_src_q  <= 3'(grant_q);
      wr_count_q     <= wr_count_q + 16'd1;
    end
  end

  assign last_wr_data = last_wr_data_q;
  assign last_wr_src  = last_wr_src_q;
  assign wr_count     = wr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vendor_wr_arbiter.sv
//------------------------------------------------------------------------------
// tb_vendor_wr_arbiter : vectors, corner sequences and randomized model check
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vendor_wr_arbiter;

  localparam int N   = 2;
  localparam int DW  = 18;
  localparam int GAP = 4;
  localparam int NR  = 2000;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req0;
  logic [N*DW-1:0] req_data, req_data0;
  logic [N-1:0]    ack, ack0;
  logic            cs, wr, busy, cs0, wr0, busy0;
  logic [31:0]     wd, wd0;
`ifdef VENDOR_WR_ARB_LASTWR_EN
  logic [DW-1:0]   lwd, lwd0;
  logic [2:0]      lws, lws0;
  logic [15:0]     wcnt, wcnt0;
`endif

  vendor_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .chipselect(cs), .write(wr), .writedata(wd), .busy(busy)
`ifdef VENDOR_WR_ARB_LASTWR_EN
    , .last_wr_data(lwd), .last_wr_src(lws), .wr_count(wcnt)
`endif
  );

  vendor_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_data(req_data0), .ack(ack0),
    .chipselect(cs0), .write(wr0), .writedata(wd0), .busy(busy0)
`ifdef VENDOR_WR_ARB_LASTWR_EN
    , .last_wr_data(lwd0), .last_wr_src(lws0), .wr_count(wcnt0)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] r, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req      = r;
    req_data = {d1, d0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; req0 = '0; req_data = '0; req_data0 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_write(input bit use0, input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if ((use0 ? wr0 : wr) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Spec rule: first requester found scanning last+1, last+2, ... mod N.
  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if ((r & (N'(1) << ((last + off) % N))) != '0) return (last + off) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]  r;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            src;
    logic [31:0]   wd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ok;
    logic [DW-1:0] dat [N];
    logic [N-1:0]  r_cur, prev_ack;
    int last_w, next_arb, wr_at, busy_end, wsrc;
    logic [DW-1:0] wdat;
    logic [31:0]   exp_wd;

    // Each entry starts from idle; expectations follow the rotation from last_grant=1 after reset.
    tbl[0] = '{2'b01, 18'h00155, 18'h00000, 0, 32'h00000155};
    tbl[1] = '{2'b11, 18'h0AAAA, 18'h12345, 1, 32'h00012345};
    tbl[2] = '{2'b11, 18'h3FFFF, 18'h00001, 0, 32'h0003FFFF};
    tbl[3] = '{2'b10, 18'h00000, 18'h20000, 1, 32'h00020000};
    tbl[4] = '{2'b10, 18'h11111, 18'h00000, 1, 32'h00000000};
    tbl[5] = '{2'b11, 18'h00001, 18'h00002, 0, 32'h00000001};

    reset = 1'b1;
    req = '0; req0 = '0; req_data = '0; req_data0 = '0;
    #1;
    check("reset ack", ack, 0);
    check("reset cs", cs, 0);
    check("reset write", wr, 0);
    check("reset writedata", wd, 0);
    check("reset busy", busy, 0);
    check("reset gap0 write", wr0, 0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].r, tbl[i].d0, tbl[i].d1);
      tick();
      check($sformatf("vec%0d grant busy", i), busy, 1);
      check($sformatf("vec%0d grant write", i), wr, 0);
      tick();
      check($sformatf("vec%0d write", i), wr, 1);
      check($sformatf("vec%0d cs", i), cs, 1);
      check($sformatf("vec%0d ack", i), ack, N'(1) << tbl[i].src);
      check($sformatf("vec%0d writedata", i), wd, tbl[i].wd);
      req = '0;
      tick();
      check($sformatf("vec%0d write drop", i), wr, 0);
      check($sformatf("vec%0d ack drop", i), ack, 0);
      check($sformatf("vec%0d wd hold", i), wd, tbl[i].wd);
      repeat (GAP - 1) tick();
      check($sformatf("vec%0d gap busy", i), busy, 1);
      tick();
      check($sformatf("vec%0d idle busy", i), busy, 0);
    end

    // Requester 1 drops its request right after arbitration.
    set_req(2'b10, 18'h00000, 18'h3FFFF);
    tick();
    req = '0;
    tick();
    check("early drop write", wr, 1);
    check("early drop ack", ack, 2'b10);
    check("early drop writedata", wd, 32'h0003FFFF);
    repeat (GAP + 1) tick();
    check("early drop idle", busy, 0);

    // Zero gap: writes every third cycle.
    req0 = 2'b10;
    req_data0 = {18'h2AAAA, 18'h00000};
    wait_write(1'b1, 10, ok);
    check("gap0 first write", ok, 1);
    check("gap0 first ack", ack0, 2'b10);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check($sformatf("gap0 write c%0d", j), wr0, (j % 3) == 0);
      check($sformatf("gap0 ack c%0d", j), ack0, ((j % 3) == 0) ? 2'b10 : 2'b00);
    end
    check("gap0 writedata", wd0, 32'h0002AAAA);
    req0 = '0;

    // Reset during the write cycle.
    set_req(2'b01, 18'h00005, 18'h00000);
    wait_write(1'b0, 10, ok);
    check("pre-reset write seen", ok, 1);
    reset = 1'b1;
    #1;
    check("reset-in-write write", wr, 0);
    check("reset-in-write cs", cs, 0);
    check("reset-in-write ack", ack, 0);
    check("reset-in-write busy", busy, 0);
    tick();
    reset = 1'b0;

    // Contention after reset: 0 first, then alternating, writes 7 cycles apart.
    set_req(2'b11, 18'h00111, 18'h00222);
    wait_write(1'b0, 4, ok);
    check("contention first write", ok, 1);
    check("contention first ack", ack, 2'b01);
    check("contention first wd", wd, 32'h00000111);
    for (int g = 1; g <= 3; g++) begin
      for (int j = 1; j <= 7; j++) begin
        tick();
        check($sformatf("contention g%0d write c%0d", g, j), wr, j == 7);
      end
      check($sformatf("contention g%0d ack", g), ack, (g % 2 == 1) ? 2'b10 : 2'b01);
      check($sformatf("contention g%0d wd", g), wd, (g % 2 == 1) ? 32'h00000222 : 32'h00000111);
    end
    req = '0;

    // Randomized traffic against a transaction-level model.
    do_reset();
    r_cur = '0; prev_ack = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    last_w = N - 1; next_arb = 0; wr_at = -1; busy_end = -1; wsrc = 0;
    wdat = '0; exp_wd = '0;
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < N; i++) begin
        if (prev_ack[i]) begin
          if ($urandom_range(2) != 0) r_cur[i] = 1'b0;
        end else if (!r_cur[i]) begin
          if ($urandom_range(2) == 0) begin
            r_cur[i] = 1'b1;
            dat[i]   = DW'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          r_cur[i] = 1'b0;
        end
        req_data[i*DW +: DW] = dat[i];
      end
      req = r_cur;
      tick();
      if (k >= next_arb && r_cur != '0) begin
        wsrc = rr(r_cur, last_w);
        for (int i = 0; i < N; i++) if (i == wsrc) wdat = dat[i];
        wr_at    = k + 1;
        busy_end = k + 1 + GAP;
        next_arb = k + 3 + GAP;
        last_w   = wsrc;
      end
      if (k == wr_at) exp_wd = 32'(wdat);
      check($sformatf("rnd write k%0d", k), wr, k == wr_at);
      check($sformatf("rnd cs k%0d", k), cs, k == wr_at);
      check($sformatf("rnd ack k%0d", k), ack, (k == wr_at) ? (N'(1) << wsrc) : N'(0));
      check($sformatf("rnd writedata k%0d", k), wd, exp_wd);
      check($sformatf("rnd busy k%0d", k), busy, k <= busy_end);
      prev_ack = ack;
    end
    req = '0;

`ifdef VENDOR_WR_ARB_LASTWR_EN
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      set_req(2'b10, 18'h00000, DW'(v));
      wait_write(1'b0, 10, ok);
      check($sformatf("lastwr write %0d", v), ok, 1);
      req = '0;
      repeat (GAP + 2) tick();
    end
    check("lastwr data", lwd, 18'h00003);
    check("lastwr src", lws, 3'd1);
    check("lastwr count", wcnt, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
